// File: rtl/bus_timer_pkg.sv
// Shared constants for the bus_timer peripheral: register byte offsets,
// CTRL/STATUS bit positions and register reset constants.
package bus_timer_pkg;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_PRESCALE = 5'h04;
    localparam logic [4:0] OFF_COUNT    = 5'h08;
    localparam logic [4:0] OFF_COMPARE  = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;

    localparam int CTRL_W          = 3;
    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IE         = 2;

    localparam int STATUS_MATCH = 0;

    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// 16-bit prescaler: emits a one-cycle tick every prescale+1 enabled cycles.
// Disabling or clearing restarts a full period.
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] pcnt_q;
    logic [15:0] pcnt_d;

    // The tick in a clearing cycle still uses the old prescale and pcnt.
    assign tick = enable && (pcnt_q == prescale);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pcnt_d = pcnt_q + 16'd1;
        if (!enable || clear || tick) begin
            pcnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer responder with prescaler, compare and sticky MATCH.
// Define BUS_TIMER_IRQ_EN to implement CTRL.IE and drive irq = MATCH & IE.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
    parameter logic [15:0] RESET_PRESCALE = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    input  logic        busWriteEnable,
    output logic        selected,
    output logic        irq
);

`ifdef BUS_TIMER_IRQ_EN
    localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 3'b111;
`else
    localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 3'b011;
`endif

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [15:0]       prescale_q, prescale_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       compare_q, compare_d;
    logic              match_q, match_d;

    logic [4:0] reg_off;
    logic       wr_en;
    logic       wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
    logic       tick;
    logic       count_hit;
    logic       unused_addr_bits;

    // Byte lanes are ignored; every access is a full word.
    assign unused_addr_bits = ^address[1:0];

    assign selected = (address[31:5] == BASE_ADDR[31:5]);
    assign reg_off  = {address[4:2], 2'b00};
    assign wr_en    = selected && busWriteEnable;

    assign wr_ctrl     = wr_en && (reg_off == OFF_CTRL);
    assign wr_prescale = wr_en && (reg_off == OFF_PRESCALE);
    assign wr_count    = wr_en && (reg_off == OFF_COUNT);
    assign wr_compare  = wr_en && (reg_off == OFF_COMPARE);
    assign wr_status   = wr_en && (reg_off == OFF_STATUS);

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (ctrl_q[CTRL_EN]),
        .clear    (wr_prescale),
        .prescale (prescale_q),
        .tick     (tick)
    );

    assign count_hit = (count_q == compare_q);

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;

        if (wr_ctrl) begin
            ctrl_d = dataIn[CTRL_W-1:0] & CTRL_WR_MASK;
        end
        if (wr_prescale) begin
            prescale_d = dataIn[15:0];
        end
        if (wr_compare) begin
            compare_d = dataIn;
        end

        // W1C is applied before the match set so a simultaneous set wins.
        if (wr_status && dataIn[STATUS_MATCH]) begin
            match_d = 1'b0;
        end
        if (tick) begin
            count_d = count_q + 32'd1;
            if (count_hit) begin
                match_d = 1'b1;
                if (ctrl_q[CTRL_AUTORELOAD]) begin
                    count_d = '0;
                end
            end
        end

        // A CPU write to COUNT overrides the tick step; the match above used the old value.
        if (wr_count) begin
            count_d = dataIn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            prescale_q <= RESET_PRESCALE;
            count_q    <= '0;
            compare_q  <= COMPARE_RESET;
            match_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
        end
    end

    always_comb begin
        dataOut = '0;
        if (selected) begin
            case (reg_off)
                OFF_CTRL:     dataOut = {29'd0, ctrl_q};
                OFF_PRESCALE: dataOut = {16'd0, prescale_q};
                OFF_COUNT:    dataOut = count_q;
                OFF_COMPARE:  dataOut = compare_q;
                OFF_STATUS:   dataOut = {31'd0, match_q};
                default:      dataOut = '0;
            endcase
        end
    end

`ifdef BUS_TIMER_IRQ_EN
    assign irq = match_q && ctrl_q[CTRL_IE];
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus random bus traffic
// compared cycle by cycle against a behavioural model of the register map.
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [15:0] RP   = 16'h0002;

`ifdef BUS_TIMER_IRQ_EN
    localparam logic [2:0] M_CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] M_CTRL_MASK = 3'b011;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        busWriteEnable;
    logic        selected;
    logic        irq;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state: the architectural registers plus the number of
    // enabled cycles elapsed in the current prescale period.
    logic [2:0]  m_ctrl;
    logic [15:0] m_pre;
    logic [15:0] m_elapsed;
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic        m_match;

    bus_timer #(
        .BASE_ADDR      (BASE),
        .RESET_PRESCALE (RP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .dataIn         (dataIn),
        .dataOut        (dataOut),
        .busWriteEnable (busWriteEnable),
        .selected       (selected),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_ctrl    = '0;
        m_pre     = RP;
        m_elapsed = '0;
        m_count   = '0;
        m_cmp     = 32'hFFFF_FFFF;
        m_match   = 1'b0;
    endfunction

    function automatic logic model_sel(input logic [31:0] a);
        return (a >> 5) == (BASE >> 5);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!model_sel(a)) return 32'd0;
        case ((a & 32'h1F) / 4)
            0:       return {29'd0, m_ctrl};
            1:       return {16'd0, m_pre};
            2:       return m_count;
            3:       return m_cmp;
            4:       return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_match && m_ctrl[2] && (M_CTRL_MASK[2] == 1'b1);
    endfunction

    // One clock edge of the timer as seen through its register map.
    function automatic void model_step(input logic [31:0] a, input logic [31:0] d, input logic we);
        logic        en, ticks, hits, wr;
        logic [2:0]  n_ctrl;
        logic [15:0] n_pre, n_elapsed;
        logic [31:0] n_count, n_cmp;
        logic        n_match;
        int          reg_n;
        en        = m_ctrl[0];
        ticks     = en && (m_elapsed == m_pre);
        hits      = ticks && (m_count == m_cmp);
        n_ctrl    = m_ctrl;
        n_pre     = m_pre;
        n_cmp     = m_cmp;
        n_elapsed = (en && !ticks) ? m_elapsed + 16'd1 : 16'd0;
        n_count   = ticks ? ((hits && m_ctrl[1]) ? 32'd0 : m_count + 32'd1) : m_count;
        n_match   = m_match || hits;
        wr        = model_sel(a) && we;
        reg_n     = int'((a & 32'h1F) / 4);
        if (wr) begin
            case (reg_n)
                0: n_ctrl = d[2:0] & M_CTRL_MASK;
                1: begin n_pre = d[15:0]; n_elapsed = 16'd0; end
                2: n_count = d;
                3: n_cmp = d;
                4: if (d[0] && !hits) n_match = 1'b0;
                default: ;
            endcase
        end
        m_ctrl    = n_ctrl;
        m_pre     = n_pre;
        m_elapsed = n_elapsed;
        m_count   = n_count;
        m_cmp     = n_cmp;
        m_match   = n_match;
    endfunction

    // One bus cycle: drive, compare combinational outputs, then cross a clock edge.
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic we);
        address        = a;
        dataIn         = d;
        busWriteEnable = we;
        #1;
        check($sformatf("dataOut@%08h", a), dataOut, model_read(a));
        check($sformatf("selected@%08h", a), {31'd0, selected}, {31'd0, model_sel(a)});
        check("irq", {31'd0, irq}, {31'd0, model_irq()});
        @(posedge clk);
        model_step(a, d, we);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        bus(BASE + off, d, 1'b1);
    endtask

    task automatic rd(input logic [31:0] off);
        bus(BASE + off, 32'd0, 1'b0);
    endtask

    task automatic peek(input string tag, input logic [31:0] off, input logic [31:0] exp);
        address        = BASE + off;
        busWriteEnable = 1'b0;
        #1;
        check(tag, dataOut, exp);
    endtask

    task automatic check_reset_values(input string tag);
        logic [31:0] exp_rst [5];
        exp_rst[0] = 32'd0;
        exp_rst[1] = {16'd0, RP};
        exp_rst[2] = 32'd0;
        exp_rst[3] = 32'hFFFF_FFFF;
        exp_rst[4] = 32'd0;
        for (int i = 0; i < 5; i++) begin
            peek($sformatf("%s_reg%0d", tag, i), 32'(i * 4), exp_rst[i]);
        end
        check({tag, "_irq"}, {31'd0, irq}, 32'd0);
    endtask

    initial begin
        reset          = 1'b0;
        address        = '0;
        dataIn         = '0;
        busWriteEnable = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b1;

        // Reset state over the bus, plus an address outside the window.
        for (int i = 0; i < 5; i++) rd(32'(i * 4));
        bus(32'h0000_2000, 32'd0, 1'b0);
        check("unsel_dataOut", dataOut, 32'd0);
        check("unsel_selected", {31'd0, selected}, 32'd0);

        // PRESCALE=3, COMPARE=5, EN|AUTORELOAD|IE: match and reload at COUNT=5.
        wr(32'h04, 32'd3);
        wr(32'h0C, 32'd5);
        wr(32'h00, 32'h7);
        for (int i = 0; i < 30; i++) rd((i % 2 == 0) ? 32'h08 : 32'h10);

        // Wrap from 0xFFFF_FFFF to 0 without a match, then match at COMPARE=0.
        wr(32'h00, 32'h0);
        wr(32'h10, 32'h1);
        wr(32'h04, 32'd0);
        wr(32'h08, 32'hFFFF_FFFE);
        wr(32'h0C, 32'd0);
        wr(32'h00, 32'h1);
        peek("wrap_fffffffe", 32'h08, 32'hFFFF_FFFE);
        rd(32'h08);
        peek("wrap_ffffffff", 32'h08, 32'hFFFF_FFFF);
        rd(32'h08);
        peek("wrap_zero", 32'h08, 32'h0);
        peek("wrap_nomatch", 32'h10, 32'h0);
        rd(32'h10);
        peek("wrap_one", 32'h08, 32'h1);
        peek("wrap_match", 32'h10, 32'h1);
        rd(32'h10);

        // W1C in the same cycle as a match set: MATCH stays set.
        wr(32'h00, 32'h0);
        wr(32'h10, 32'h1);
        wr(32'h0C, 32'd10);
        wr(32'h08, 32'd8);
        wr(32'h00, 32'h7);
        rd(32'h08);
        rd(32'h08);
        wr(32'h10, 32'h1);
        peek("w1c_race", 32'h10, 32'h1);
        rd(32'h10);
        wr(32'h10, 32'h1);
        peek("w1c_clear", 32'h10, 32'h0);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        rd(32'h10);

        // COUNT write on a tick cycle wins over the increment.
        wr(32'h0C, 32'hFFFF_FFFF);
        wr(32'h00, 32'h1);
        rd(32'h08);
        wr(32'h08, 32'h100);
        peek("count_wr_tick", 32'h08, 32'h100);
        rd(32'h08);

        // CTRL.IE alone: stored only when the IRQ feature is built in.
        wr(32'h00, 32'h4);
        rd(32'h00);

        // Random traffic, biased toward small values so matches occur.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, d;
            int          r;
            r = int'($urandom_range(0, 99));
            a = BASE + ($urandom_range(0, 7) * 4) + $urandom_range(0, 3);
            if (r < 5) a = $urandom;
            case ((a & 32'h1F) / 4)
                0:       d = $urandom_range(0, 7);
                1:       d = $urandom_range(0, 3);
                2, 3:    d = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 12);
                default: d = $urandom;
            endcase
            bus(a, d, (r >= 60));
        end

        // Asynchronous reset mid-count.
        wr(32'h00, 32'h0);
        wr(32'h04, 32'd0);
        wr(32'h0C, 32'hFFFF_FFFF);
        wr(32'h08, 32'h40);
        wr(32'h00, 32'h1);
        rd(32'h08);
        rd(32'h08);
        peek("pre_reset_count", 32'h08, 32'h42);
        reset = 1'b0;
        model_reset();
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) rd(32'(i * 4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
